branch_resolve_queue: RTL and testbench

//  In-order queue of in-flight predicted branches between fetch and EX. Fetch pushes

---
 rtl/branch_resolve_queue_pkg.sv | 11 +
 rtl/brq_storage.sv | 41 ++++
 rtl/branch_resolve_queue.sv | 101 ++++++++++
 tb/tb_branch_resolve_queue.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/branch_resolve_queue_pkg.sv
// rtl/branch_resolve_queue_pkg.sv - shared state encodings and constants for the branch resolve queue
package branch_resolve_queue_pkg;

  typedef enum logic {
    BRQ_RUN   = 1'b0,
    BRQ_FLUSH = 1'b1
  } brq_state_e;

  localparam int BRQ_PC_INC = 4;

endpackage

// File: rtl/brq_storage.sv
// rtl/brq_storage.sv - DEPTH-entry {pc,target,predict} register file, one write port, async head read
module brq_storage #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_wr_en,
  input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
  input  logic [PC_W-1:0]          i_wr_pc,
  input  logic [PC_W-1:0]          i_wr_target,
  input  logic                     i_wr_predict,
  input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
  output logic [PC_W-1:0]          o_rd_pc,
  output logic [PC_W-1:0]          o_rd_target,
  output logic                     o_rd_predict
);

  logic [PC_W-1:0] r_pc      [DEPTH];
  logic [PC_W-1:0] r_target  [DEPTH];
  logic            r_predict [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_pc[i]      <= '0;
        r_target[i]  <= '0;
        r_predict[i] <= 1'b0;
      end
    end else if (i_wr_en) begin
      r_pc[i_wr_addr]      <= i_wr_pc;
      r_target[i_wr_addr]  <= i_wr_target;
      r_predict[i_wr_addr] <= i_wr_predict;
    end
  end

  assign o_rd_pc      = r_pc[i_rd_addr];
  assign o_rd_target  = r_target[i_rd_addr];
  assign o_rd_predict = r_predict[i_rd_addr];

endmodule

// File: rtl/branch_resolve_queue.sv
// rtl/branch_resolve_queue.sv - in-order queue of predicted branches; resolves head, drives predictor
// correction and fetch redirect, and flushes younger entries on a mispredict.
module branch_resolve_queue
  import branch_resolve_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_valid,
  input  logic [PC_W-1:0]        push_pc,
  input  logic [PC_W-1:0]        push_target,
  input  logic                   push_predict,
  output logic                   push_ready,
  input  logic                   resolve_valid,
  input  logic                   resolve_taken,
  input  logic [PC_W-1:0]        resolve_target,
  output logic                   update_valid,
  output logic                   correction,
  output logic                   mispredict,
  output logic [PC_W-1:0]        redirect_pc,
  output logic                   resolve_err,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  brq_state_e      r_state;
  logic [PW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            r_update_valid, r_correction, r_mispredict, r_resolve_err;
  logic [PC_W-1:0] r_redirect_pc;

  logic [PC_W-1:0] w_head_pc, w_head_target;
  logic            w_head_predict;
  logic            w_res_acc, w_mis, w_push_acc;

  brq_storage #(.DEPTH(DEPTH), .PC_W(PC_W)) u_storage (
    .clk          (clk),
    .rst_n        (reset),
    .i_wr_en      (w_push_acc),
    .i_wr_addr    (r_wr_ptr),
    .i_wr_pc      (push_pc),
    .i_wr_target  (push_target),
    .i_wr_predict (push_predict),
    .i_rd_addr    (r_rd_ptr),
    .o_rd_pc      (w_head_pc),
    .o_rd_target  (w_head_target),
    .o_rd_predict (w_head_predict)
  );

  assign w_res_acc  = resolve_valid && (r_count != '0);
  assign w_mis      = w_res_acc && ((w_head_predict != resolve_taken) ||
                      (w_head_predict && resolve_taken && (w_head_target != resolve_target)));
  assign push_ready = (r_state == BRQ_RUN) && ((r_count < CW'(DEPTH)) || w_res_acc);
  // A push alongside a mispredicting resolve is wrong-path and never written.
  assign w_push_acc = push_valid && push_ready && !w_mis;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= BRQ_RUN;
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_update_valid <= 1'b0;
      r_correction   <= 1'b0;
      r_mispredict   <= 1'b0;
      r_resolve_err  <= 1'b0;
      r_redirect_pc  <= '0;
    end else begin
      r_update_valid <= w_res_acc;
      r_mispredict   <= w_mis;
      r_resolve_err  <= resolve_valid && (r_count == '0);
      if (w_res_acc) begin
        r_correction  <= resolve_taken;
        r_redirect_pc <= resolve_taken ? resolve_target : w_head_pc + PC_W'(BRQ_PC_INC);
      end
      if (w_mis) begin
        r_state  <= BRQ_FLUSH;
        r_rd_ptr <= r_rd_ptr + PW'(1);
        r_wr_ptr <= r_rd_ptr + PW'(1);
        r_count  <= '0;
      end else begin
        r_state  <= BRQ_RUN;
        r_rd_ptr <= r_rd_ptr + PW'(w_res_acc);
        r_wr_ptr <= r_wr_ptr + PW'(w_push_acc);
        r_count  <= r_count + CW'(w_push_acc) - CW'(w_res_acc);
      end
    end
  end

  assign update_valid = r_update_valid;
  assign correction   = r_correction;
  assign mispredict   = r_mispredict;
  assign redirect_pc  = r_redirect_pc;
  assign resolve_err  = r_resolve_err;
  assign count        = r_count;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// tb/tb_branch_resolve_queue.sv - scoreboard bench for branch_resolve_queue
module tb_branch_resolve_queue;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        push_valid = 1'b0, push_predict = 1'b0, push_ready;
  logic [31:0] push_pc = '0, push_target = '0;
  logic        resolve_valid = 1'b0, resolve_taken = 1'b0;
  logic [31:0] resolve_target = '0;
  logic        update_valid, correction, mispredict, resolve_err;
  logic [31:0] redirect_pc;
  logic [2:0]  count;

  logic        p12_valid = 1'b0, p12_predict = 1'b0, p12_ready;
  logic [11:0] p12_pc = '0, p12_target = '0;
  logic        r12_valid = 1'b0, r12_taken = 1'b0;
  logic [11:0] r12_target = '0;
  logic        u12_valid, c12, m12, e12;
  logic [11:0] rpc12;
  logic [2:0]  cnt12;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    bit          err;
    bit          corr;
    bit          mis;
    logic [31:0] rpc;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  branch_resolve_queue #(.DEPTH(4), .PC_W(32)) dut (
    .clk(clk), .reset(reset),
    .push_valid(push_valid), .push_pc(push_pc), .push_target(push_target),
    .push_predict(push_predict), .push_ready(push_ready),
    .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
    .resolve_target(resolve_target),
    .update_valid(update_valid), .correction(correction), .mispredict(mispredict),
    .redirect_pc(redirect_pc), .resolve_err(resolve_err), .count(count)
  );

  branch_resolve_queue #(.DEPTH(4), .PC_W(12)) dut12 (
    .clk(clk), .reset(reset),
    .push_valid(p12_valid), .push_pc(p12_pc), .push_target(p12_target),
    .push_predict(p12_predict), .push_ready(p12_ready),
    .resolve_valid(r12_valid), .resolve_taken(r12_taken),
    .resolve_target(r12_target),
    .update_valid(u12_valid), .correction(c12), .mispredict(m12),
    .redirect_pc(rpc12), .resolve_err(e12), .count(cnt12)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every strobe from the DUT consumes one expected response.
  always @(negedge clk) begin
    if (reset && (update_valid || mispredict || resolve_err)) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_strobe: got upd=%0b mis=%0b err=%0b expected none",
                 update_valid, mispredict, resolve_err);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("resolve_err", {31'b0, resolve_err}, {31'b0, e.err});
        chk("update_valid", {31'b0, update_valid}, {31'b0, !e.err});
        if (!e.err) begin
          chk("correction", {31'b0, correction}, {31'b0, e.corr});
          chk("mispredict", {31'b0, mispredict}, {31'b0, e.mis});
          if (e.mis) chk("redirect_pc", redirect_pc, e.rpc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_push(input logic [31:0] pc, input logic [31:0] tgt, input logic pred);
    push_valid = 1'b1; push_pc = pc; push_target = tgt; push_predict = pred;
    tick();
    push_valid = 1'b0;
  endtask

  task automatic expect_resp(input bit err, input bit corr, input bit mis, input logic [31:0] rpc);
    exp_t e;
    e.err = err; e.corr = corr; e.mis = mis; e.rpc = rpc;
    exp_q.push_back(e);
  endtask

  task automatic do_resolve(input logic taken, input logic [31:0] tgt,
                            input bit mis, input logic [31:0] rpc);
    resolve_valid = 1'b1; resolve_taken = taken; resolve_target = tgt;
    expect_resp(1'b0, taken, mis, rpc);
    tick();
    resolve_valid = 1'b0;
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_count", {29'b0, count}, 32'd0);
    chk("rst_update_valid", {31'b0, update_valid}, 32'd0);
    chk("rst_mispredict", {31'b0, mispredict}, 32'd0);
    chk("rst_redirect_pc", redirect_pc, 32'd0);
    reset = 1'b1;
    tick();
    chk("idle_push_ready", {31'b0, push_ready}, 32'd1);

    // correct taken prediction
    do_push(32'h100, 32'h140, 1'b1);
    chk("t1_count_push", {29'b0, count}, 32'd1);
    do_resolve(1'b1, 32'h140, 1'b0, 32'h0);
    chk("t1_count", {29'b0, count}, 32'd0);

    // predicted not-taken, actually taken: redirect to actual target, flush cycle
    do_push(32'h200, 32'h240, 1'b0);
    do_resolve(1'b1, 32'h300, 1'b1, 32'h300);
    chk("t2_flush_push_ready", {31'b0, push_ready}, 32'd0);
    push_valid = 1'b1; push_pc = 32'h222;
    tick();
    push_valid = 1'b0;
    chk("t2_flush_push_dropped", {29'b0, count}, 32'd0);
    chk("t2_run_push_ready", {31'b0, push_ready}, 32'd1);

    // predicted taken, actually not-taken: redirect to pc+4
    do_push(32'h7FC, 32'h900, 1'b1);
    do_resolve(1'b0, 32'h0, 1'b1, 32'h800);
    tick();

    // fill, dropped 5th push, push+resolve at full
    do_push(32'h10, 32'h1000, 1'b0);
    do_push(32'h20, 32'h2000, 1'b0);
    do_push(32'h30, 32'h3000, 1'b0);
    do_push(32'h40, 32'h4000, 1'b0);
    chk("t4_full_count", {29'b0, count}, 32'd4);
    chk("t4_full_push_ready", {31'b0, push_ready}, 32'd0);
    do_push(32'h50, 32'h555, 1'b1);
    chk("t4_dropped_count", {29'b0, count}, 32'd4);
    push_valid = 1'b1; push_pc = 32'h60; push_target = 32'h600; push_predict = 1'b1;
    chk("t4_ready_with_resolve", {31'b0, push_ready}, 32'd0);
    resolve_valid = 1'b1; resolve_taken = 1'b0; resolve_target = 32'h0;
    #1;
    chk("t4_ready_with_resolve_acc", {31'b0, push_ready}, 32'd1);
    expect_resp(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    push_valid = 1'b0; resolve_valid = 1'b0;
    chk("t4_simul_count", {29'b0, count}, 32'd4);
    do_resolve(1'b0, 32'h0, 1'b0, 32'h0);
    do_resolve(1'b0, 32'h0, 1'b0, 32'h0);
    do_resolve(1'b0, 32'h0, 1'b0, 32'h0);
    chk("t4_one_left", {29'b0, count}, 32'd1);
    do_resolve(1'b0, 32'h0, 1'b1, 32'h64);
    tick();

    // mispredict with concurrent push, then resolve on empty
    do_push(32'h300, 32'h3800, 1'b0);
    do_push(32'h310, 32'h3900, 1'b0);
    do_push(32'h320, 32'h3a00, 1'b0);
    chk("t5_count3", {29'b0, count}, 32'd3);
    push_valid = 1'b1; push_pc = 32'h330; push_target = 32'h3b00; push_predict = 1'b0;
    do_resolve(1'b1, 32'h380, 1'b1, 32'h380);
    push_valid = 1'b0;
    chk("t5_flushed", {29'b0, count}, 32'd0);
    resolve_valid = 1'b1; resolve_taken = 1'b0;
    expect_resp(1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    resolve_valid = 1'b0;
    tick();
    chk("t5_push_discarded", {29'b0, count}, 32'd0);

    // asynchronous reset mid-stream
    do_push(32'h400, 32'h4400, 1'b0);
    do_push(32'h410, 32'h4410, 1'b0);
    do_push(32'h420, 32'h4420, 1'b0);
    chk("t6_count3", {29'b0, count}, 32'd3);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_rst_count", {29'b0, count}, 32'd0);
    chk("t6_rst_update_valid", {31'b0, update_valid}, 32'd0);
    chk("t6_rst_correction", {31'b0, correction}, 32'd0);
    chk("t6_rst_mispredict", {31'b0, mispredict}, 32'd0);
    chk("t6_rst_resolve_err", {31'b0, resolve_err}, 32'd0);
    chk("t6_rst_redirect_pc", redirect_pc, 32'd0);
    tick();
    reset = 1'b1;
    repeat (3) tick();
    chk("t6_post_count", {29'b0, count}, 32'd0);

    // 12-bit PC wrap on the not-taken redirect
    p12_valid = 1'b1; p12_pc = 12'hFFC; p12_target = 12'h010; p12_predict = 1'b1;
    tick();
    p12_valid = 1'b0;
    r12_valid = 1'b1; r12_taken = 1'b0;
    tick();
    r12_valid = 1'b0;
    chk("w12_update_valid", {31'b0, u12_valid}, 32'd1);
    chk("w12_mispredict", {31'b0, m12}, 32'd1);
    chk("w12_redirect_pc", {20'b0, rpc12}, 32'h000);
    repeat (2) tick();

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
